// File: rtl/r16_bank_wr_sched.sv
// Write scheduler for one radix-16 memory bank: a 2-entry ping-pong of 16-lane result
// vectors drained one lane per cycle into the bank's 16:1 write-port mux.
module r16_bank_wr_sched #(
  parameter int D_WIDTH = 64,
  parameter int A_WIDTH = 64,
  parameter int STRIDE  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*D_WIDTH-1:0] in_data,
  input  logic [A_WIDTH-1:0]    in_base_addr,
  input  logic                  hold,
  output logic [16*A_WIDTH-1:0] a_out,
  output logic [16*D_WIDTH-1:0] d_out,
  output logic [3:0]            sel_out,
  output logic                  w_enable,
  output logic                  vec_done,
  output logic                  busy
);

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready.
  // in_ready is a function of buffer occupancy only and never looks at in_valid.

  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [16*D_WIDTH-1:0] r_data [2];
  logic [16*A_WIDTH-1:0] r_addr [2];
  logic [1:0]            r_full;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [3:0]            r_cnt;

  logic                  w_accept;
  logic                  w_issue;
  logic                  w_retire;
  logic [16*A_WIDTH-1:0] w_addr;

  assign in_ready = ~(r_full[0] & r_full[1]);
  assign w_accept = in_valid & in_ready;
  assign w_issue  = (r_state == ST_DRAIN) & ~hold;
  assign w_retire = w_issue & (r_cnt == 4'd15);

  // Lane addresses are fixed at accept time so draining never needs an adder.
  always_comb begin
    w_addr = '0;
    for (int k = 0; k < 16; k++) begin
      w_addr[k*A_WIDTH +: A_WIDTH] = in_base_addr + (A_WIDTH'(k) * A_WIDTH'(STRIDE));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The other slot is either already full or being filled on this same edge.
        if (w_retire && !r_full[~r_rd_ptr] && !w_accept) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_enable = 1'b0;
    vec_done = 1'b0;
    sel_out  = 4'd0;
    a_out    = '0;
    d_out    = '0;
    if (r_state == ST_DRAIN) begin
      w_enable = w_issue;
      vec_done = w_retire;
      sel_out  = r_cnt;
      a_out    = r_addr[r_rd_ptr];
      d_out    = r_data[r_rd_ptr];
    end
  end

  assign busy = r_full[0] | r_full[1];

  // Accept only targets an empty slot, so accept and retire never touch the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_addr[i] <= '0;
      end
      r_full   <= 2'b00;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 4'd0;
    end else begin
      if (w_accept) begin
        r_data[r_wr_ptr] <= in_data;
        r_addr[r_wr_ptr] <= w_addr;
        r_full[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_retire) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ~r_rd_ptr;
      end
      if (w_issue) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule
